dtmr_pool_ctrl: RTL and testbench

Parametrised dynamic-redundancy controller for a pool of N identical redundant modules. A K-of-M sensor vote or an excessive received-error rate switches the pool from single-module operation to full redundant voting. Modules with persistent faults are retired, and a soft restart occurs when too few modules remain. A hold-off timer adds hysteresis before the pool returns to single-module mode. The block sits between the sensor/link-quality front end and the enable inputs of the redundant datapath modules.

---
 rtl/dtmr_pool_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dtmr_pool_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtmr_pool_ctrl.sv
// -----------------------------------------------------------------------------
// dtmr_pool_ctrl
//
// Dynamic-redundancy controller for a pool of N_MOD identical modules.
// In IDLE a single default module is enabled. A K-of-N sensor vote or an
// excessive error rate switches the pool to ACTIVE, where every non-retired
// module is enabled for voting. Modules that fault for FAULT_MAX consecutive
// cycles are retired. When fewer than MIN_LIVE modules remain the pool is
// soft-restarted. After the trigger clears, HOLD keeps the pool redundant for
// HOLD_CYC trigger-free cycles before dropping back to IDLE.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   sens       trigger sensor inputs (active-high)
//   err_rate   received-data error rate
//   fault      per-module fault flags from the voter
//   en         per-module enables
//   mode       0=IDLE, 1=ACTIVE, 2=HOLD
//   def_idx    module enabled while in IDLE
//   dis_mask   retired-module flags
//   restart_p  one-cycle soft-restart pulse
// -----------------------------------------------------------------------------
module dtmr_pool_ctrl #(
    parameter int N_MOD     = 3,
    parameter int N_SENS    = 4,
    parameter int SENS_K    = 3,
    parameter int ERR_W     = 4,
    parameter int ERR_TH    = 5,
    parameter int FAULT_MAX = 5,
    parameter int MIN_LIVE  = 2,
    parameter int HOLD_CYC  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SENS-1:0]        sens,
    input  logic [ERR_W-1:0]         err_rate,
    input  logic [N_MOD-1:0]         fault,
    output logic [N_MOD-1:0]         en,
    output logic [1:0]               mode,
    output logic [$clog2(N_MOD)-1:0] def_idx,
    output logic [N_MOD-1:0]         dis_mask,
    output logic                     restart_p
);

    localparam int DW = $clog2(N_MOD);
    localparam int SW = $clog2(N_SENS + 1);
    localparam int LW = $clog2(N_MOD + 1);
    localparam int FW = $clog2(FAULT_MAX + 1);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [SW-1:0]    SENS_K_V     = SW'(SENS_K);
    localparam logic [ERR_W-1:0] ERR_TH_V     = ERR_W'(ERR_TH);
    localparam logic [LW-1:0]    MIN_LIVE_V   = LW'(MIN_LIVE);
    localparam logic [FW-1:0]    FAULT_MAX_V  = FW'(FAULT_MAX);
    localparam logic [FW-1:0]    FAULT_LAST_V = FW'(FAULT_MAX - 1);
    localparam logic [HW-1:0]    HOLD_LOAD_V  = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } mode_t;

    mode_t           state;
    logic [HW-1:0]   hold_cnt;
    logic [FW-1:0]   fcnt [N_MOD];

    logic [SW-1:0]   sens_cnt;
    logic [LW-1:0]   live_cnt;
    logic [DW-1:0]   first_live;
    logic            trig;
    logic            collapse;
    logic            go_idle;

    // NOTE: every always_comb output gets a default before any conditional
    // update so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        sens_cnt = '0;
        for (int i = 0; i < N_SENS; i++) begin
            sens_cnt = sens_cnt + SW'(sens[i]);
        end
        live_cnt = '0;
        for (int i = 0; i < N_MOD; i++) begin
            live_cnt = live_cnt + LW'(!dis_mask[i]);
        end
        // Scan downwards so the lowest live index wins; 0 if all are retired.
        first_live = '0;
        for (int i = N_MOD - 1; i >= 0; i--) begin
            if (!dis_mask[i]) first_live = DW'(i);
        end
    end

    assign trig     = (sens_cnt >= SENS_K_V) || (err_rate > ERR_TH_V);
    assign collapse = (state != IDLE) && (live_cnt < MIN_LIVE_V);
    assign go_idle  = !trig && (((state == ACTIVE) && (HOLD_CYC == 0)) ||
                                ((state == HOLD) && (hold_cnt == '0)));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            def_idx   <= '0;
            dis_mask  <= '0;
            restart_p <= 1'b0;
            // NOTE: the fault counters are a handful of flops, not a memory,
            // so they are reset along with the rest of the control state.
            for (int i = 0; i < N_MOD; i++) fcnt[i] <= '0;
        end else begin
            restart_p <= 1'b0;

            case (state)
                IDLE: begin
                    if (trig) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (!trig) begin
                        if (HOLD_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD_V;
                        end
                    end
                end
                HOLD: begin
                    if (trig) begin
                        state <= ACTIVE;
                    end else if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Exit and collapse both clear the pool; a coincident pair still
            // yields a single restart pulse. def_idx uses the pre-clear mask.
            if (go_idle || collapse) begin
                restart_p <= 1'b1;
                dis_mask  <= '0;
                for (int i = 0; i < N_MOD; i++) fcnt[i] <= '0;
                if (go_idle) def_idx <= first_live;
            end else if (state != IDLE) begin
                for (int i = 0; i < N_MOD; i++) begin
                    if (!dis_mask[i]) begin
                        if (fault[i]) begin
                            if (fcnt[i] == FAULT_LAST_V) dis_mask[i] <= 1'b1;
                            if (fcnt[i] != FAULT_MAX_V)  fcnt[i] <= fcnt[i] + FW'(1);
                        end else begin
                            fcnt[i] <= '0;
                        end
                    end
                end
            end
        end
    end

    assign mode = state;
    assign en   = (state == IDLE) ? (N_MOD'(1) << def_idx) : ~dis_mask;

endmodule

// File: tb/tb_dtmr_pool_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dtmr_pool_ctrl
//
// Two instances share one stimulus stream: one with the default hold-off
// (8 cycles) and one with HOLD_CYC=0. A driver applies inputs on the falling
// edge, advances a behavioural pool model and queues the expected post-edge
// outputs; an independent monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_dtmr_pool_ctrl;

    localparam int N_MOD     = 3;
    localparam int N_SENS    = 4;
    localparam int SENS_K    = 3;
    localparam int ERR_W     = 4;
    localparam int ERR_TH    = 5;
    localparam int FAULT_MAX = 5;
    localparam int MIN_LIVE  = 2;
    localparam int DW        = $clog2(N_MOD);

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_HOLD   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_SENS-1:0] sens;
    logic [ERR_W-1:0]  err_rate;
    logic [N_MOD-1:0]  fault;

    logic [N_MOD-1:0]  en_a, dis_a, en_b, dis_b;
    logic [1:0]        mode_a, mode_b;
    logic [DW-1:0]     def_a, def_b;
    logic              rp_a, rp_b;

    always #5 clk = ~clk;

    dtmr_pool_ctrl #(
        .N_MOD(N_MOD), .N_SENS(N_SENS), .SENS_K(SENS_K), .ERR_W(ERR_W),
        .ERR_TH(ERR_TH), .FAULT_MAX(FAULT_MAX), .MIN_LIVE(MIN_LIVE), .HOLD_CYC(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .sens(sens), .err_rate(err_rate), .fault(fault),
        .en(en_a), .mode(mode_a), .def_idx(def_a), .dis_mask(dis_a), .restart_p(rp_a)
    );

    dtmr_pool_ctrl #(
        .N_MOD(N_MOD), .N_SENS(N_SENS), .SENS_K(SENS_K), .ERR_W(ERR_W),
        .ERR_TH(ERR_TH), .FAULT_MAX(FAULT_MAX), .MIN_LIVE(MIN_LIVE), .HOLD_CYC(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .sens(sens), .err_rate(err_rate), .fault(fault),
        .en(en_b), .mode(mode_b), .def_idx(def_b), .dis_mask(dis_b), .restart_p(rp_b)
    );

    typedef struct {
        logic [1:0]       mode;
        logic [N_MOD-1:0] en;
        logic [N_MOD-1:0] dis;
        logic [DW-1:0]    def_idx;
        logic             rp;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_mode [2];
    int               m_held [2];   // trigger-free cycles spent in HOLD so far
    int               m_def  [2];
    int               m_fc   [2][N_MOD];
    logic [N_MOD-1:0] m_ret  [2];
    logic             m_rp   [2];

    function automatic int hold_of(input int k);
        return (k == 0) ? 8 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE;
            m_held[k] = 0;
            m_def[k]  = 0;
            m_ret[k]  = '0;
            m_rp[k]   = 1'b0;
            for (int i = 0; i < N_MOD; i++) m_fc[k][i] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit trig, input logic [N_MOD-1:0] f,
                              output exp_t e);
        int nxt;
        bit leave;
        bit coll;
        coll  = (m_mode[k] != M_IDLE) && ((N_MOD - $countones(m_ret[k])) < MIN_LIVE);
        nxt   = m_mode[k];
        leave = 1'b0;
        if (trig) begin
            nxt = M_ACTIVE;
        end else if (m_mode[k] == M_ACTIVE) begin
            if (hold_of(k) == 0) begin
                nxt   = M_IDLE;
                leave = 1'b1;
            end else begin
                nxt       = M_HOLD;
                m_held[k] = 0;
            end
        end else if (m_mode[k] == M_HOLD) begin
            m_held[k]++;
            if (m_held[k] >= hold_of(k)) begin
                nxt   = M_IDLE;
                leave = 1'b1;
            end
        end

        m_rp[k] = leave || coll;
        if (leave) begin
            m_def[k] = 0;
            for (int i = 0; i < N_MOD; i++) begin
                if (!m_ret[k][i]) begin
                    m_def[k] = i;
                    break;
                end
            end
        end
        if (leave || coll) begin
            m_ret[k] = '0;
            for (int i = 0; i < N_MOD; i++) m_fc[k][i] = 0;
        end else if (m_mode[k] != M_IDLE) begin
            for (int i = 0; i < N_MOD; i++) begin
                if (!m_ret[k][i]) begin
                    if (f[i]) begin
                        m_fc[k][i]++;
                        if (m_fc[k][i] >= FAULT_MAX) m_ret[k][i] = 1'b1;
                    end else begin
                        m_fc[k][i] = 0;
                    end
                end
            end
        end
        m_mode[k] = nxt;

        e.mode    = 2'(m_mode[k]);
        e.en      = (m_mode[k] == M_IDLE) ? (N_MOD'(1) << m_def[k]) : ~m_ret[k];
        e.dis     = m_ret[k];
        e.def_idx = DW'(m_def[k]);
        e.rp      = m_rp[k];
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [N_SENS-1:0] s, input logic [ERR_W-1:0] er,
                        input logic [N_MOD-1:0] f);
        exp_t ea, eb;
        bit   t;
        @(negedge clk);
        sens     = s;
        err_rate = er;
        fault    = f;
        t = ($countones(s) >= SENS_K) || (int'(er) > ERR_TH);
        model_step(0, t, f, ea);
        model_step(1, t, f, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic steps(input int n, input logic [N_SENS-1:0] s,
                         input logic [ERR_W-1:0] er, input logic [N_MOD-1:0] f);
        for (int i = 0; i < n; i++) step(s, er, f);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " mode_a"}, 32'(mode_a), 0);
        check({tag, " en_a"},   32'(en_a),   1);
        check({tag, " dis_a"},  32'(dis_a),  0);
        check({tag, " def_a"},  32'(def_a),  0);
        check({tag, " rp_a"},   32'(rp_a),   0);
        check({tag, " mode_b"}, 32'(mode_b), 0);
        check({tag, " en_b"},   32'(en_b),   1);
        check({tag, " dis_b"},  32'(dis_b),  0);
        check({tag, " def_b"},  32'(def_b),  0);
        check({tag, " rp_b"},   32'(rp_b),   0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("a.mode",      32'(mode_a), 32'(e.mode));
                check("a.en",        32'(en_a),   32'(e.en));
                check("a.dis_mask",  32'(dis_a),  32'(e.dis));
                check("a.def_idx",   32'(def_a),  32'(e.def_idx));
                check("a.restart_p", 32'(rp_a),   32'(e.rp));
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("b.mode",      32'(mode_b), 32'(e.mode));
                check("b.en",        32'(en_b),   32'(e.en));
                check("b.dis_mask",  32'(dis_b),  32'(e.dis));
                check("b.def_idx",   32'(def_b),  32'(e.def_idx));
                check("b.restart_p", 32'(rp_b),   32'(e.rp));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        sens     = '0;
        err_rate = '0;
        fault    = '0;
        model_reset();
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // K-of-N boundary: two sensors and err_rate at threshold do not trigger.
        steps(3, 4'b0011, 4'd5, 3'b000);
        // Three sensors trigger; then a quiet stretch exercises hold-off / exit.
        step(4'b0111, 4'd0, 3'b000);
        steps(10, 4'b0000, 4'd0, 3'b000);

        // Persistent fault on module 0 retires it; four faults then a clean
        // sample on module 1 must not retire it.
        steps(6, 4'b0111, 4'd0, 3'b001);
        step(4'b0111, 4'd0, 3'b000);
        steps(4, 4'b0111, 4'd0, 3'b010);
        step(4'b0111, 4'd0, 3'b000);
        // Drop the trigger: default module rotates to index 1.
        steps(10, 4'b0000, 4'd0, 3'b000);

        // Live collapse: retire modules 0 and 2 together.
        step(4'b1110, 4'd0, 3'b000);
        steps(5, 4'b1110, 4'd0, 3'b101);
        steps(2, 4'b1110, 4'd0, 3'b000);
        steps(10, 4'b0000, 4'd0, 3'b000);

        // Error-rate threshold: 5 is quiet, 6 triggers.
        steps(2, 4'b0000, 4'd5, 3'b000);
        step(4'b0000, 4'd6, 3'b000);
        steps(3, 4'b0000, 4'd0, 3'b000);

        // Asynchronous reset in HOLD, sampled well away from any clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomised bursts of quiet / noisy traffic with a per-burst bad set.
        for (int b = 0; b < 150; b++) begin
            int               len;
            bit               quiet;
            logic [N_MOD-1:0] bad;
            len   = $urandom_range(1, 14);
            quiet = 1'($urandom_range(0, 1));
            bad   = N_MOD'($urandom_range(0, 7));
            for (int j = 0; j < len; j++) begin
                logic [N_SENS-1:0] s;
                logic [ERR_W-1:0]  er;
                logic [N_MOD-1:0]  f;
                s = N_SENS'($urandom);
                if (quiet) begin
                    if ($countones(s) >= SENS_K) s = s & 4'b0011;
                    er = ERR_W'($urandom_range(0, ERR_TH));
                end else begin
                    er = ERR_W'($urandom_range(0, 15));
                end
                f = bad & (($urandom_range(0, 7) != 0) ? 3'b111 : N_MOD'($urandom));
                step(s, er, f);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_a drained", 32'(q_a.size()), 0);
        check("queue_b drained", 32'(q_b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
